// File: rtl/vproc_mem_pkg.sv
// Shared types and elaboration helpers for the vector-memory width splitter.
package vproc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } vmem_split_state_e;

  function automatic bit vmem_split_widths_ok(int unsigned vw, int unsigned dw);
    return (dw >= 32) && (vw >= dw) && ((vw % dw) == 0) &&
           ((vw & (vw - 1)) == 0) && ((dw & (dw - 1)) == 0);
  endfunction

endpackage

// File: rtl/vproc_lsb_idx.sv
// Index of the lowest set bit of a vector, plus a flag telling whether any bit is set.
module vproc_lsb_idx #(
  parameter int unsigned W = 2,
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = W; i > 0; i--) begin
      if (vec_i[i-1]) begin
        idx_o = IW'(i - 1);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vproc_vmem_splitter.sv
// Splits one wide vector-memory request into narrow data-memory beats and
// reassembles the in-order narrow responses into a single wide response.
module vproc_vmem_splitter
  import vproc_mem_pkg::*;
#(
  parameter int unsigned VMEM_W = 128,
  parameter int unsigned DMEM_W = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                vmem_req_i,
  output logic                vmem_gnt_o,
  input  logic [31:0]         vmem_addr_i,
  input  logic                vmem_we_i,
  input  logic [VMEM_W/8-1:0] vmem_be_i,
  input  logic [VMEM_W-1:0]   vmem_wdata_i,
  output logic                vmem_rvalid_o,
  output logic [VMEM_W-1:0]   vmem_rdata_o,
  output logic                vmem_err_o,
  output logic                dmem_req_o,
  input  logic                dmem_gnt_i,
  output logic [31:0]         dmem_addr_o,
  output logic                dmem_we_o,
  output logic [DMEM_W/8-1:0] dmem_be_o,
  output logic [DMEM_W-1:0]   dmem_wdata_o,
  input  logic                dmem_rvalid_i,
  input  logic [DMEM_W-1:0]   dmem_rdata_i,
  input  logic                dmem_err_i
);

  localparam int unsigned NBEATS    = VMEM_W / DMEM_W;
  localparam int unsigned DBYTES    = DMEM_W / 8;
  localparam int unsigned VBYTES    = VMEM_W / 8;
  localparam int unsigned IW        = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [31:0] ADDR_MASK = ~32'(VBYTES - 1);

  if (!vmem_split_widths_ok(VMEM_W, DMEM_W)) begin : g_width_err
    $error("vproc_vmem_splitter: unsupported VMEM_W/DMEM_W combination");
  end

  vmem_split_state_e   state_q, state_d;
  logic [31:0]         base_q, base_d;
  logic                we_q, we_d;
  logic [VBYTES-1:0]   be_q, be_d;
  logic [VMEM_W-1:0]   wdata_q, wdata_d;
  logic [NBEATS-1:0]   iss_q, iss_d;
  logic [NBEATS-1:0]   pnd_q, pnd_d;
  logic [VMEM_W-1:0]   rbuf_q, rbuf_d;
  logic                err_q, err_d;

  logic [NBEATS-1:0]   en;
  logic [IW-1:0]       iss_idx, pnd_idx;
  logic                iss_any, pnd_any;

  vproc_lsb_idx #(.W(NBEATS)) u_iss_idx (
    .vec_i (iss_q),
    .idx_o (iss_idx),
    .any_o (iss_any)
  );

  vproc_lsb_idx #(.W(NBEATS)) u_pnd_idx (
    .vec_i (pnd_q),
    .idx_o (pnd_idx),
    .any_o (pnd_any)
  );

  always_comb begin
    en = '0;
    for (int unsigned k = 0; k < NBEATS; k++) begin
      en[k] = |vmem_be_i[k*DBYTES +: DBYTES];
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    we_d    = we_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    iss_d   = iss_q;
    pnd_d   = pnd_q;
    rbuf_d  = rbuf_q;
    err_d   = err_q;

    vmem_gnt_o    = 1'b0;
    vmem_rvalid_o = 1'b0;
    vmem_rdata_o  = '0;
    vmem_err_o    = 1'b0;
    dmem_req_o    = 1'b0;
    dmem_addr_o   = '0;
    dmem_we_o     = 1'b0;
    dmem_be_o     = '0;
    dmem_wdata_o  = '0;

    unique case (state_q)
      IDLE: begin
        vmem_gnt_o = vmem_req_i;
        if (vmem_req_i) begin
          base_d  = vmem_addr_i & ADDR_MASK;
          we_d    = vmem_we_i;
          be_d    = vmem_be_i;
          wdata_d = vmem_wdata_i;
          iss_d   = en;
          pnd_d   = en;
          rbuf_d  = '0;
          err_d   = 1'b0;
          state_d = (en != '0) ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        dmem_req_o   = iss_any;
        dmem_addr_o  = base_q + 32'(iss_idx) * DBYTES;
        dmem_we_o    = we_q;
        dmem_be_o    = be_q[32'(iss_idx)*DBYTES +: DBYTES];
        dmem_wdata_o = wdata_q[32'(iss_idx)*DMEM_W +: DMEM_W];
        if (dmem_gnt_i && iss_any) begin
          iss_d[iss_idx] = 1'b0;
        end
      end
      WAIT: ;
      RESP: begin
        vmem_rvalid_o = 1'b1;
        vmem_rdata_o  = rbuf_q;
        vmem_err_o    = err_q;
        state_d       = IDLE;
      end
    endcase

    // Responses may coincide with a grant of a later beat; both masks update together.
    if ((state_q == ISSUE || state_q == WAIT) && dmem_rvalid_i && pnd_any) begin
      pnd_d[pnd_idx] = 1'b0;
      if (!we_q) begin
        rbuf_d[32'(pnd_idx)*DMEM_W +: DMEM_W] = dmem_rdata_i;
      end
      err_d = err_q | dmem_err_i;
    end

    if (state_q == ISSUE && iss_d == '0) begin
      state_d = (pnd_d == '0) ? RESP : WAIT;
    end
    if (state_q == WAIT && pnd_d == '0) begin
      state_d = RESP;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      base_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      iss_q   <= '0;
      pnd_q   <= '0;
      rbuf_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      we_q    <= we_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      iss_q   <= iss_d;
      pnd_q   <= pnd_d;
      rbuf_q  <= rbuf_d;
      err_q   <= err_d;
    end
  end

  rvalid_protocol_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    dmem_rvalid_i |-> ((state_q == ISSUE || state_q == WAIT) && pnd_any));

endmodule
